// File: rtl/waverforms_mul_rr_arbiter_if.sv
// Request/response bundle between the waveform datapath requesters and the shared multiplier.
// master = requester side, slave = arbiter/multiplier side.
interface waverforms_mul_rr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DIN0_WIDTH = 15,
    parameter int DIN1_WIDTH = 15,
    parameter int DOUT_WIDTH = 30
);
    logic                            mul_ce;
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ*DIN0_WIDTH-1:0]   req_din0;
    logic [NUM_REQ*DIN1_WIDTH-1:0]   req_din1;
    logic [NUM_REQ-1:0]              rsp_valid;
    logic [DOUT_WIDTH-1:0]           rsp_dout;
    logic                            busy;

    modport master (
        output mul_ce, req_valid, req_din0, req_din1,
        input  req_ready, rsp_valid, rsp_dout, busy
    );

    modport slave (
        input  mul_ce, req_valid, req_din0, req_din1,
        output req_ready, rsp_valid, rsp_dout, busy
    );
endinterface

// File: rtl/waverforms_mul_rr_arbiter.sv
// Round-robin shared unsigned multiplier with a MUL_STAGES-deep pipeline and one-hot tagged results.
// Define WAVERFORMS_MUL_ARB_STATS_EN to add saturating grant/conflict counters.
module waverforms_mul_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DIN0_WIDTH = 15,
    parameter int DIN1_WIDTH = 15,
    parameter int DOUT_WIDTH = 30,
    parameter int MUL_STAGES = 2
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    waverforms_mul_rr_arbiter_if.slave   bus
`ifdef WAVERFORMS_MUL_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]        stat_grants,
    output logic [15:0]                  stat_conflicts
`endif
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PROD_W = DIN0_WIDTH + DIN1_WIDTH;

    function automatic logic [DOUT_WIDTH-1:0] mul_trunc(input logic [DIN0_WIDTH-1:0] a,
                                                        input logic [DIN1_WIDTH-1:0] b);
        logic [PROD_W-1:0] p;
        p = PROD_W'(a) * PROD_W'(b);
        return DOUT_WIDTH'(p);
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      gidx;
    logic                  found;
    logic [NUM_REQ-1:0]    grant;
    logic                  accept;
    logic [DIN0_WIDTH-1:0] a_sel;
    logic [DIN1_WIDTH-1:0] b_sel;

    // Arbitration: first valid index at or after ptr, wrapping; nothing granted in reset or stall.
    always_comb begin : arb
        int j;
        gidx  = '0;
        found = 1'b0;
        grant = '0;
        j     = 0;
        if (!ap_rst && bus.mul_ce) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                j = int'(ptr) + k;
                if (j >= NUM_REQ) j = j - NUM_REQ;
                if (!found && bus.req_valid[j]) begin
                    found = 1'b1;
                    gidx  = IDX_W'(j);
                end
            end
        end
        if (found) grant[gidx] = 1'b1;
    end

    assign bus.req_ready = grant;
    assign accept        = |(bus.req_valid & grant);
    assign a_sel         = bus.req_din0[gidx*DIN0_WIDTH +: DIN0_WIDTH];
    assign b_sel         = bus.req_din1[gidx*DIN1_WIDTH +: DIN1_WIDTH];

    always_ff @(posedge ap_clk) begin
        if (ap_rst)      ptr <= '0;
        else if (accept) ptr <= next_idx(gidx);
    end

    // Pipeline control: valid and owner tag shift one stage per enabled cycle.
    logic [MUL_STAGES:1]   vld_p;
    logic [IDX_W-1:0]      tag_p [1:MUL_STAGES];
    logic [DOUT_WIDTH-1:0] prod_last;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            vld_p <= '0;
        end else if (bus.mul_ce) begin
            vld_p[1] <= accept;
            for (int k = 2; k <= MUL_STAGES; k++) vld_p[k] <= vld_p[k-1];
        end
    end

    always_ff @(posedge ap_clk) begin
        if (bus.mul_ce) begin
            tag_p[1] <= gidx;
            for (int k = 2; k <= MUL_STAGES; k++) tag_p[k] <= tag_p[k-1];
        end
    end

    // Datapath: a stage only loads when the op ahead of it is valid, so rsp_dout holds the last result.
    generate
        if (MUL_STAGES == 1) begin : g_one
            always_ff @(posedge ap_clk) begin
                if (ap_rst)                      prod_last <= '0;
                else if (bus.mul_ce && accept)   prod_last <= mul_trunc(a_sel, b_sel);
            end
        end else begin : g_multi
            logic [DIN0_WIDTH-1:0] a_p1;
            logic [DIN1_WIDTH-1:0] b_p1;
            logic [DOUT_WIDTH-1:0] prod_p [2:MUL_STAGES];

            // Stage 1: registered operands.
            always_ff @(posedge ap_clk) begin
                if (bus.mul_ce && accept) begin
                    a_p1 <= a_sel;
                    b_p1 <= b_sel;
                end
            end

            // Stage 2..MUL_STAGES: product, then delay registers; the last one is rsp_dout.
            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    for (int k = 2; k <= MUL_STAGES; k++) prod_p[k] <= '0;
                end else if (bus.mul_ce) begin
                    if (vld_p[1]) prod_p[2] <= mul_trunc(a_p1, b_p1);
                    for (int k = 3; k <= MUL_STAGES; k++)
                        if (vld_p[k-1]) prod_p[k] <= prod_p[k-1];
                end
            end

            assign prod_last = prod_p[MUL_STAGES];
        end
    endgenerate

    // Output: a stalled cycle hides the pending result, which then reappears on re-enable.
    logic [NUM_REQ-1:0] rsp_valid_c;
    always_comb begin
        rsp_valid_c = '0;
        if (vld_p[MUL_STAGES] && bus.mul_ce) rsp_valid_c[tag_p[MUL_STAGES]] = 1'b1;
    end

    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_dout  = prod_last;
    assign bus.busy      = |vld_p;

`ifdef WAVERFORMS_MUL_ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic [15:0] grant_cnt [NUM_REQ];
    logic [15:0] conflict_cnt;
    logic        multi_req;

    assign multi_req = |(bus.req_valid & (bus.req_valid - NUM_REQ'(1)));

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
            conflict_cnt <= '0;
        end else if (bus.mul_ce) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (accept && gidx == IDX_W'(i)) grant_cnt[i] <= sat_inc(grant_cnt[i]);
            if (multi_req) conflict_cnt <= sat_inc(conflict_cnt);
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NUM_REQ; i++) stat_grants[i*16 +: 16] = grant_cnt[i];
    end

    assign stat_conflicts = conflict_cnt;
`endif

endmodule

// File: tb/tb_waverforms_mul_rr_arbiter.sv
// Directed bench for waverforms_mul_rr_arbiter: reset, single op, round-robin, operand limits, stall, flush.
module tb_waverforms_mul_rr_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DW0     = 15;
    localparam int DW1     = 15;
    localparam int DOW     = 30;
    localparam int MS      = 2;

    logic ap_clk = 1'b0;
    logic ap_rst;
    int   tests = 0;
    int   fails = 0;

    always #5 ap_clk = ~ap_clk;

    waverforms_mul_rr_arbiter_if #(
        .NUM_REQ(NUM_REQ), .DIN0_WIDTH(DW0), .DIN1_WIDTH(DW1), .DOUT_WIDTH(DOW)
    ) bus ();

`ifdef WAVERFORMS_MUL_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] stat_grants;
    logic [15:0]           stat_conflicts;
`endif

    waverforms_mul_rr_arbiter #(
        .NUM_REQ(NUM_REQ), .DIN0_WIDTH(DW0), .DIN1_WIDTH(DW1), .DOUT_WIDTH(DOW), .MUL_STAGES(MS)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst(ap_rst),
        .bus(bus)
`ifdef WAVERFORMS_MUL_ARB_STATS_EN
        ,
        .stat_grants(stat_grants),
        .stat_conflicts(stat_conflicts)
`endif
    );

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [DW0-1:0] a, input logic [DW1-1:0] b);
        bus.req_din0[i*DW0 +: DW0] = a;
        bus.req_din1[i*DW1 +: DW1] = b;
    endtask

    task automatic do_reset();
        ap_rst        = 1'b1;
        bus.mul_ce    = 1'b1;
        bus.req_valid = '0;
        step();
        step();
        ap_rst = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst        = 1'b1;
        bus.mul_ce    = 1'b1;
        bus.req_valid = 4'b0100;
        set_op(2, 15'd3, 15'd5);
        step();
        step();
        @(negedge ap_clk);
        tests++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
        tests++; if (bus.rsp_valid !== 4'b0000) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0000", bus.rsp_valid); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        tests++; if (bus.rsp_dout !== 30'd0) begin fails++; $display("FAIL reset_dout: got %h expected 0", bus.rsp_dout); end
        step();
        ap_rst        = 1'b0;
        bus.req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge ap_clk);
            tests++; if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0) begin
                fails++; $display("FAIL reset_no_accept c%0d: rsp_valid=%b busy=%b expected 0000/0", c, bus.rsp_valid, bus.busy);
            end
            step();
        end
    endtask

    task automatic test_single();
        bus.req_valid = 4'b0100;
        set_op(2, 15'h0003, 15'h0005);
        @(negedge ap_clk);
        tests++; if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b expected 0100", bus.req_ready); end
        step();
        bus.req_valid = '0;
        @(negedge ap_clk);
        tests++; if (bus.busy !== 1'b1 || bus.rsp_valid !== 4'b0000) begin
            fails++; $display("FAIL single_c1: busy=%b rsp_valid=%b expected 1/0000", bus.busy, bus.rsp_valid);
        end
        step();
        @(negedge ap_clk);
        tests++; if (bus.rsp_valid !== 4'b0100) begin fails++; $display("FAIL single_rsp_valid: got %b expected 0100", bus.rsp_valid); end
        tests++; if (bus.rsp_dout !== 30'd15) begin fails++; $display("FAIL single_dout: got %0d expected 15", bus.rsp_dout); end
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL single_busy_c2: got %b expected 1", bus.busy); end
        step();
        @(negedge ap_clk);
        tests++; if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0 || bus.rsp_dout !== 30'd15) begin
            fails++; $display("FAIL single_c3: rsp_valid=%b busy=%b dout=%0d expected 0000/0/15", bus.rsp_valid, bus.busy, bus.rsp_dout);
        end
        step();
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_rdy  [4];
        logic [29:0] exp_prod [4];
        exp_rdy  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_prod = '{30'h0000_7FFF, 30'h0000_FFFE, 30'h0001_7FFD, 30'h0001_FFFC};
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 15'(i + 1), 15'h7FFF);
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 11; c++) begin
            if (c == 8) bus.req_valid = '0;
            @(negedge ap_clk);
            if (c < 8) begin
                tests++; if (bus.req_ready !== exp_rdy[c % 4]) begin
                    fails++; $display("FAIL rr_grant c%0d: got %b expected %b", c, bus.req_ready, exp_rdy[c % 4]);
                end
            end
            if (c >= 2 && c < 10) begin
                tests++; if (bus.rsp_valid !== exp_rdy[(c - 2) % 4] || bus.rsp_dout !== exp_prod[(c - 2) % 4]) begin
                    fails++; $display("FAIL rr_rsp c%0d: got %b/%h expected %b/%h", c, bus.rsp_valid, bus.rsp_dout,
                                      exp_rdy[(c - 2) % 4], exp_prod[(c - 2) % 4]);
                end
            end
            if (c == 10) begin
                tests++; if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0) begin
                    fails++; $display("FAIL rr_drain: rsp_valid=%b busy=%b expected 0000/0", bus.rsp_valid, bus.busy);
                end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        bus.req_valid = 4'b0010;
        set_op(1, 15'h7FFF, 15'h7FFF);
        @(negedge ap_clk);
        tests++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL b2b_ready0: got %b expected 0010", bus.req_ready); end
        step();
        set_op(1, 15'h0000, 15'h7FFF);
        @(negedge ap_clk);
        tests++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL b2b_ready1: got %b expected 0010", bus.req_ready); end
        step();
        bus.req_valid = '0;
        @(negedge ap_clk);
        tests++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_dout !== 30'h3FFF0001) begin
            fails++; $display("FAIL max_product: got %b/%h expected 0010/3fff0001", bus.rsp_valid, bus.rsp_dout);
        end
        step();
        @(negedge ap_clk);
        tests++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_dout !== 30'd0) begin
            fails++; $display("FAIL zero_product: got %b/%h expected 0010/0", bus.rsp_valid, bus.rsp_dout);
        end
        step();
        @(negedge ap_clk);
        tests++; if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL b2b_drain: rsp_valid=%b busy=%b expected 0000/0", bus.rsp_valid, bus.busy);
        end
        step();
    endtask

    task automatic test_stall();
        do_reset();
        bus.req_valid = 4'b0001;
        set_op(0, 15'd6, 15'd7);
        @(negedge ap_clk);
        tests++; if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL stall_accept: got %b expected 0001", bus.req_ready); end
        step();
        bus.mul_ce    = 1'b0;
        bus.req_valid = 4'b0010;
        set_op(1, 15'd1, 15'd1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge ap_clk);
            tests++; if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b1) begin
                fails++; $display("FAIL stall_c%0d: ready=%b rsp_valid=%b busy=%b expected 0000/0000/1", c,
                                  bus.req_ready, bus.rsp_valid, bus.busy);
            end
            step();
        end
        bus.mul_ce    = 1'b1;
        bus.req_valid = '0;
        @(negedge ap_clk);
        tests++; if (bus.rsp_valid !== 4'b0000) begin fails++; $display("FAIL stall_c4: got %b expected 0000", bus.rsp_valid); end
        step();
        @(negedge ap_clk);
        tests++; if (bus.rsp_valid !== 4'b0001 || bus.rsp_dout !== 30'd42) begin
            fails++; $display("FAIL stall_rsp_c5: got %b/%0d expected 0001/42", bus.rsp_valid, bus.rsp_dout);
        end
        step();
        // Stall in the very cycle the result is at the output.
        bus.req_valid = 4'b0100;
        set_op(2, 15'd9, 15'd9);
        @(negedge ap_clk);
        tests++; if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL ostall_accept: got %b expected 0100", bus.req_ready); end
        step();
        bus.req_valid = '0;
        step();
        bus.mul_ce = 1'b0;
        @(negedge ap_clk);
        tests++; if (bus.rsp_valid !== 4'b0000 || bus.rsp_dout !== 30'd81) begin
            fails++; $display("FAIL ostall_hidden: got %b/%0d expected 0000/81", bus.rsp_valid, bus.rsp_dout);
        end
        step();
        bus.mul_ce = 1'b1;
        @(negedge ap_clk);
        tests++; if (bus.rsp_valid !== 4'b0100 || bus.rsp_dout !== 30'd81) begin
            fails++; $display("FAIL ostall_reappear: got %b/%0d expected 0100/81", bus.rsp_valid, bus.rsp_dout);
        end
        step();
        @(negedge ap_clk);
        tests++; if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL ostall_once: rsp_valid=%b busy=%b expected 0000/0", bus.rsp_valid, bus.busy);
        end
        step();
    endtask

    task automatic test_reset_flush();
        // ptr is 3 here: requester 2 is granted, then requester 1, leaving ptr at 2.
        bus.req_valid = 4'b0100;
        set_op(2, 15'd2, 15'd2);
        @(negedge ap_clk);
        tests++; if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL flush_acc0: got %b expected 0100", bus.req_ready); end
        step();
        bus.req_valid = 4'b0010;
        set_op(1, 15'd3, 15'd3);
        @(negedge ap_clk);
        tests++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL flush_acc1: got %b expected 0010", bus.req_ready); end
        step();
        bus.req_valid = 4'b0001;
        ap_rst        = 1'b1;
        @(negedge ap_clk);
        tests++; if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b1) begin
            fails++; $display("FAIL flush_rst_cycle: ready=%b busy=%b expected 0000/1", bus.req_ready, bus.busy);
        end
        step();
        ap_rst        = 1'b0;
        bus.req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge ap_clk);
            tests++; if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0) begin
                fails++; $display("FAIL flush_quiet c%0d: rsp_valid=%b busy=%b expected 0000/0", c, bus.rsp_valid, bus.busy);
            end
            step();
        end
        bus.req_valid = 4'b1010;
        set_op(1, 15'd4, 15'd5);
        set_op(3, 15'd1, 15'd1);
        @(negedge ap_clk);
        tests++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL flush_ptr0: got %b expected 0010", bus.req_ready); end
        step();
        bus.req_valid = '0;
        step();
        @(negedge ap_clk);
        tests++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_dout !== 30'd20) begin
            fails++; $display("FAIL flush_next_rsp: got %b/%0d expected 0010/20", bus.rsp_valid, bus.rsp_dout);
        end
        step();
    endtask

`ifdef WAVERFORMS_MUL_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        set_op(0, 15'd1, 15'd1);
        set_op(1, 15'd1, 15'd1);
        bus.req_valid = 4'b0011;
        for (int c = 0; c < 10; c++) step();
        bus.req_valid = '0;
        @(negedge ap_clk);
        tests++; if (stat_grants[15:0] !== 16'd5) begin fails++; $display("FAIL stat_grants0: got %0d expected 5", stat_grants[15:0]); end
        tests++; if (stat_grants[31:16] !== 16'd5) begin fails++; $display("FAIL stat_grants1: got %0d expected 5", stat_grants[31:16]); end
        tests++; if (stat_conflicts !== 16'd10) begin fails++; $display("FAIL stat_conflicts: got %0d expected 10", stat_conflicts); end
        step();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ap_rst        = 1'b1;
        bus.mul_ce    = 1'b1;
        bus.req_valid = '0;
        bus.req_din0  = '0;
        bus.req_din1  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_stall();
        test_reset_flush();
`ifdef WAVERFORMS_MUL_ARB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
